// File: rtl/parent_rr_sched.sv
// parent_rr_sched: round-robin SLEEP->COOK->BOOK service sequencer; PARENT_NAP_EN adds a NAP cool-down after BOOK
module parent_rr_sched #(
  parameter int N_CHILD  = 4,
  parameter int COOK_CYC = 3,
  parameter int BOOK_CYC = 2,
  parameter int NAP_CYC  = 2,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic [N_CHILD-1:0] wakeup,
  output logic [N_CHILD-1:0] food,
  output logic [N_CHILD-1:0] book,
  output logic [N_CHILD-1:0] done,
  output logic               busy
);
  localparam int IW = N_CHILD > 1 ? $clog2(N_CHILD) : 1;
  localparam logic [1:0] SLEEP = 2'd0;
  localparam logic [1:0] COOK  = 2'd1;
  localparam logic [1:0] BOOK  = 2'd2;
`ifdef PARENT_NAP_EN
  localparam logic [1:0] NAP   = 2'd3;
`endif
  if (N_CHILD < 1 || N_CHILD > 16 || COOK_CYC < 1 || COOK_CYC > 2**CNT_W ||
      BOOK_CYC < 1 || BOOK_CYC > 2**CNT_W || NAP_CYC < 1 || NAP_CYC > 2**CNT_W) begin : g_bad_param
    $error("parent_rr_sched: parameter out of range");
  end
  logic [1:0]         state, state_d;
  logic [IW-1:0]      sel, sel_d, ptr, ptr_d, grant;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               hit;
  logic [N_CHILD-1:0] oh;
  // first requester found scanning from ptr upward with wrap
  always_comb begin
    hit   = 1'b0;
    grant = ptr;
    for (int i = 0; i < N_CHILD; i++)
      if (!hit && wakeup[(int'(ptr) + i) % N_CHILD]) begin
        hit   = 1'b1;
        grant = IW'((int'(ptr) + i) % N_CHILD);
      end
  end
  // next state, selected child, dwell counter and rotation pointer
  always_comb begin
    state_d = SLEEP;
    sel_d   = sel;
    cnt_d   = '0;
    ptr_d   = ptr;
    case (state)
      SLEEP: begin
        state_d = hit ? COOK : SLEEP;
        sel_d   = hit ? grant : sel;
        cnt_d   = hit ? CNT_W'(COOK_CYC - 1) : '0;
      end
      COOK: begin
        state_d = cnt == '0 ? BOOK : COOK;
        cnt_d   = cnt == '0 ? CNT_W'(BOOK_CYC - 1) : cnt - CNT_W'(1);
      end
      BOOK: begin
        ptr_d   = cnt == '0 ? (sel == IW'(N_CHILD - 1) ? '0 : sel + IW'(1)) : ptr;
`ifdef PARENT_NAP_EN
        state_d = cnt == '0 ? NAP : BOOK;
        cnt_d   = cnt == '0 ? CNT_W'(NAP_CYC - 1) : cnt - CNT_W'(1);
`else
        state_d = cnt == '0 ? SLEEP : BOOK;
        cnt_d   = cnt == '0 ? '0 : cnt - CNT_W'(1);
`endif
      end
`ifdef PARENT_NAP_EN
      NAP: begin
        state_d = cnt == '0 ? SLEEP : NAP;
        cnt_d   = cnt == '0 ? '0 : cnt - CNT_W'(1);
      end
`endif
      default: ;
    endcase
  end
  assign oh = N_CHILD'(1) << sel_d;
  // outputs are registered from the next state so they move with the state register
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state <= SLEEP;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      food  <= '0;
      book  <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      food  <= state_d == COOK ? oh : '0;
      book  <= state_d == BOOK ? oh : '0;
      done  <= state_d == BOOK && cnt_d == '0 ? oh : '0;
      busy  <= state_d != SLEEP;
    end
endmodule

// File: tb/tb_parent_rr_sched.sv
// tb_parent_rr_sched: directed checks of the round-robin parent sequencer
module tb_parent_rr_sched;
  logic       clk;
  logic       resetb;
  logic [3:0] wakeup;
  logic [3:0] food, book, done;
  logic       busy;
  int checks = 0;
  int errors = 0;

  parent_rr_sched dut (
    .clk(clk), .resetb(resetb), .wakeup(wakeup),
    .food(food), .book(book), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    wakeup = 4'b0000;
    step(2);
    checks++;
    if ({food, book, done, busy} !== 13'b0) begin
      errors++;
      $display("FAIL reset_hold got %b%b%b%b want all zero", food, book, done, busy);
    end
    resetb = 1'b1;
    step(2);
    checks++;
    if ({food, book, done, busy} !== 13'b0) begin
      errors++;
      $display("FAIL reset_idle got %b%b%b%b want all zero", food, book, done, busy);
    end
  endtask

  task automatic test_single;
    logic [12:0] e;
    wakeup = 4'b0001;
    step(1);
    wakeup = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      e = {c < 3 ? 4'b0001 : 4'b0000, (c == 3 || c == 4) ? 4'b0001 : 4'b0000,
           c == 4 ? 4'b0001 : 4'b0000, c < 5};
      checks++;
      if ({food, book, done, busy} !== e) begin
        errors++;
        $display("FAIL single_c%0d got %b want %b", c, {food, book, done, busy}, e);
      end
      step(1);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] oh;
    resetb = 1'b0;
    #1;
    resetb = 1'b1;
    step(1);
    wakeup = 4'b1111;
    step(1);
    for (int s = 0; s < 5; s++) begin
      oh = 4'b0001 << (s % 4);
      checks++;
      if (food !== oh) begin
        errors++;
        $display("FAIL rr_grant%0d food %b want %b", s, food, oh);
      end
      step(4);
      checks++;
      if ({book, done} !== {oh, oh}) begin
        errors++;
        $display("FAIL rr_done%0d book/done %b/%b want %b/%b", s, book, done, oh, oh);
      end
      step(1);
      checks++;
      if ({food, book, busy} !== 9'b0) begin
        errors++;
        $display("FAIL rr_gap%0d food/book/busy %b/%b/%b want zero", s, food, book, busy);
      end
      if (s == 4) wakeup = 4'b0000;
      step(1);
    end
  endtask

  task automatic test_scan;
    wakeup = 4'b0100;
    step(1);
    wakeup = 4'b0000;
    checks++;
    if (food !== 4'b0100) begin
      errors++;
      $display("FAIL scan_c2 food %b want 0100", food);
    end
    step(5);
    wakeup = 4'b0101;
    step(1);
    checks++;
    if (food !== 4'b0001) begin
      errors++;
      $display("FAIL scan_first food %b want 0001", food);
    end
    step(6);
    wakeup = 4'b0000;
    checks++;
    if (food !== 4'b0100) begin
      errors++;
      $display("FAIL scan_second food %b want 0100", food);
    end
    step(6);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL scan_idle busy %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    wakeup = 4'b0010;
    step(1);
    checks++;
    if (food !== 4'b0010) begin
      errors++;
      $display("FAIL mid_grant food %b want 0010", food);
    end
    wakeup = 4'b0000;
    step(1);
    #2 resetb = 1'b0;
    #1;
    checks++;
    if ({food, book, done, busy} !== 13'b0) begin
      errors++;
      $display("FAIL mid_async got %b%b%b%b want all zero", food, book, done, busy);
    end
    for (int c = 0; c < 4; c++) begin
      step(1);
      checks++;
      if ({done, busy} !== 5'b0) begin
        errors++;
        $display("FAIL mid_hold%0d done/busy %b/%b want zero", c, done, busy);
      end
    end
    resetb = 1'b1;
    wakeup = 4'b0010;
    step(1);
    wakeup = 4'b0000;
    checks++;
    if (food !== 4'b0010) begin
      errors++;
      $display("FAIL mid_restart food %b want 0010", food);
    end
    step(6);
    resetb = 1'b0;
    #1;
    resetb = 1'b1;
    wakeup = 4'b1010;
    step(1);
    wakeup = 4'b0000;
    checks++;
    if (food !== 4'b0010) begin
      errors++;
      $display("FAIL mid_ptr0 food %b want 0010", food);
    end
    step(6);
  endtask

`ifdef PARENT_NAP_EN
  task automatic test_nap;
    resetb = 1'b0;
    #1;
    resetb = 1'b1;
    wakeup = 4'b0011;
    step(1);
    step(4);
    checks++;
    if (done !== 4'b0001) begin
      errors++;
      $display("FAIL nap_done done %b want 0001", done);
    end
    for (int c = 0; c < 2; c++) begin
      step(1);
      checks++;
      if ({food, book, done, busy} !== 13'b1) begin
        errors++;
        $display("FAIL nap_idle%0d got %b%b%b%b want busy only", c, food, book, done, busy);
      end
    end
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL nap_sleep busy %b want 0", busy);
    end
    step(1);
    wakeup = 4'b0000;
    checks++;
    if (food !== 4'b0010) begin
      errors++;
      $display("FAIL nap_period food %b want 0010", food);
    end
    step(10);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_scan;
    test_reset_mid;
`ifdef PARENT_NAP_EN
    test_nap;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
